// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and constants for the multi-port register file
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam logic [DATA_W_DEF-1:0] WORD_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending bits per register with reserve-over-write priority and registered population count
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [ADDR_W:0]       pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  always_comb begin
    pend_d = pend_q;
    if (wr0_en) pend_d[wr0_addr] = 1'b0;
    if (wr1_en) pend_d[wr1_addr] = 1'b0;
    if (rsv_en) pend_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
    cnt_d = (ADDR_W+1)'($countones(pend_d));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
  assign pending  = pend_q;
  assign pend_cnt = cnt_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read, dual-write register file with optional write bypass and pending scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     wr_conflict,
  output logic [ADDR_W:0]          pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DATA_W-1:0] ZERO_W = DATA_W'(WORD_ZERO);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              conf_q, conf_d;
  logic [DEPTH-1:0]  pending;
  always_comb begin
    mem_d = mem_q;
    if (wr0_en) mem_d[wr0_addr] = wr0_data;
    if (wr1_en) mem_d[wr1_addr] = wr1_data;
    if (ZERO_REG != 0) mem_d[0] = ZERO_W;
    conf_d = conf_q | (wr0_en & wr1_en & (wr0_addr == wr1_addr) & ~((ZERO_REG != 0) && (wr0_addr == '0)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: ZERO_W};
      conf_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      conf_q <= conf_d;
    end
  end
  assign wr_conflict = conf_q;
  reg_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );
  // a forwarded write also hides the pending flag, since the value is now available
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              h0, h1, zr;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    assign h0 = (BYPASS != 0) && wr0_en && (wr0_addr == ra);
    assign h1 = (BYPASS != 0) && wr1_en && (wr1_addr == ra);
    assign zr = (ZERO_REG != 0) && (ra == '0);
    assign rd_data[i*DATA_W +: DATA_W] = zr ? ZERO_W : h1 ? wr1_data : h0 ? wr0_data : mem_q[ra];
    assign rd_busy[i] = pending[ra] & ~(h0 | h1);
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized scoreboard bench comparing bypass and non-bypass instances against a behavioural model
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic        wr0_en = 1'b0, wr1_en = 1'b0, rsv_en = 1'b0;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0, rsv_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [5:0]  pend_cnt_b, pend_cnt_n;
  logic        conf_b, conf_n;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [63:0] rdb, rdn;
    logic [1:0]  bb, bn;
    logic [5:0]  cnt;
    logic        conf;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [31:0] m_reg [32];
  bit          m_pend [32];
  bit          m_conf;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_conflict(conf_b), .pend_cnt(pend_cnt_b)
  );
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_conflict(conf_n), .pend_cnt(pend_cnt_n)
  );

  function automatic bit wr_hits(logic [4:0] a);
    return (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a, bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(logic [4:0] a, bit byp);
    return m_pend[a] && !(byp && wr_hits(a));
  endfunction

  function automatic logic [5:0] m_count();
    int n = 0;
    for (int k = 0; k < 32; k++) n += int'(m_pend[k]);
    return 6'(n);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      m_reg[k]  = 32'h0;
      m_pend[k] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  task automatic model_edge();
    if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] = wr1_data;
    if (wr0_en && wr1_en && wr0_addr == wr1_addr && wr0_addr != 0) m_conf = 1'b1;
    if (wr0_en) m_pend[wr0_addr] = 1'b0;
    if (wr1_en) m_pend[wr1_addr] = 1'b0;
    if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
  endtask

  task automatic push_exp();
    exp_t x;
    logic [4:0] a0, a1;
    a0 = rd_addr[4:0];
    a1 = rd_addr[9:5];
    x.rdb  = {m_read(a1, 1'b1), m_read(a0, 1'b1)};
    x.rdn  = {m_read(a1, 1'b0), m_read(a0, 1'b0)};
    x.bb   = {m_busy(a1, 1'b1), m_busy(a0, 1'b1)};
    x.bn   = {m_busy(a1, 1'b0), m_busy(a0, 1'b0)};
    x.cnt  = m_count();
    x.conf = m_conf;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic cyc(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                     input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                     input logic re, input logic [4:0] ra, input logic [4:0] r0, input logic [4:0] r1);
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    rsv_en = re;  rsv_addr = ra;  rd_addr = {r1, r0};
    push_exp();
    tick();
  endtask

  task automatic mid_reset(input logic [4:0] r0, input logic [4:0] r1);
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0; rd_addr = {r1, r0};
    rst_n = 1'b0;
    #1;
    model_clear();
    push_exp();
    @(negedge clk);
    #1;
    wr0_en = 1'b1; wr0_addr = r0; wr0_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = r1;
    tick();
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_data_byp", rd_data_b, e.rdb);
      chk("rd_data_nobyp", rd_data_n, e.rdn);
      chk("rd_busy_byp", 64'(rd_busy_b), 64'(e.bb));
      chk("rd_busy_nobyp", 64'(rd_busy_n), 64'(e.bn));
      chk("pend_cnt_byp", 64'(pend_cnt_b), 64'(e.cnt));
      chk("pend_cnt_nobyp", 64'(pend_cnt_n), 64'(e.cnt));
      chk("wr_conflict_byp", 64'(conf_b), 64'(e.conf));
      chk("wr_conflict_nobyp", 64'(conf_n), 64'(e.conf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd31);
    rst_n = 1'b1;
    cyc(1, 5'd1, 32'h0000FFFF, 0, 0, 0, 0, 0, 5'd1, 5'd31);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd31);
    cyc(1, 5'd30, 32'h11111111, 1, 5'd30, 32'h22222222, 0, 0, 5'd30, 5'd30);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd30, 5'd1);
    cyc(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd30);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd5);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5);
    cyc(1, 5'd3, 32'hAAAA5555, 0, 0, 0, 1, 5'd3, 5'd3, 5'd5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd5);
    cyc(0, 0, 0, 1, 5'd5, 32'h0BADF00D, 0, 0, 5'd3, 5'd5);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd5);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd7);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd7);
    mid_reset(5'd3, 5'd7);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd30, 5'd1);
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      if (k == 200) mid_reset(5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
